// File: rtl/wb_arbiter_2m_if.sv
// rtl/wb_arbiter_2m_if.sv - Classic 32-bit Wishbone bus bundle shared by the arbiter and its neighbours.
interface wb_bus;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic        ack;
  logic        err;
  logic [31:0] dat_r;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  ack, err, dat_r
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output ack, err, dat_r
  );
endinterface

// File: rtl/wb_arbiter_2m.sv
// rtl/wb_arbiter_2m.sv - Two-master round-robin Wishbone arbiter, grant held per CYC frame.
// Optional stuck-slave watchdog with DRAIN state is built when WB_ARB_TIMEOUT_EN is defined.
module wb_arbiter_2m #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk_in,
  input  logic       reset_in,
  wb_bus.slave       m0_bus,
  wb_bus.slave       m1_bus,
  wb_bus.master      out_bus,
  output logic [1:0] grant_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
`ifdef WB_ARB_TIMEOUT_EN
    OWN1 = 2'd2,
    DRAIN = 2'd3
`else
    OWN1 = 2'd2
`endif
  } state_t;

  state_t state_q, state_d;
  // Set means m1 was granted most recently; while owning or draining it also names the owner.
  logic last_grant_q, last_grant_d;

  logic        own0, own1, own_any;
  logic        own_cyc, own_stb, own_we;
  logic [31:0] own_adr, own_dat_w;
  logic [3:0]  own_sel;
  logic        timeout_hit;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_cycles_out_of_range
  end

  assign own0    = (state_q == OWN0);
  assign own1    = (state_q == OWN1);
  assign own_any = own0 | own1;

  assign own_cyc   = last_grant_q ? m1_bus.cyc   : m0_bus.cyc;
  assign own_stb   = last_grant_q ? m1_bus.stb   : m0_bus.stb;
  assign own_we    = last_grant_q ? m1_bus.we    : m0_bus.we;
  assign own_adr   = last_grant_q ? m1_bus.adr   : m0_bus.adr;
  assign own_dat_w = last_grant_q ? m1_bus.dat_w : m0_bus.dat_w;
  assign own_sel   = last_grant_q ? m1_bus.sel   : m0_bus.sel;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;

  // Fires on the TIMEOUT_CYCLES-th unanswered strobe cycle; independent of ack to avoid a loop via the slave.
  assign timeout_hit = own_any & own_cyc & own_stb & (cnt_q == TMO_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!own_any) begin
      cnt_d = 16'd0;
    end else if (out_bus.ack || out_bus.err) begin
      cnt_d = 16'd0;
    end else if (own_cyc && own_stb) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (m0_bus.cyc && (!m1_bus.cyc || last_grant_q)) begin
          state_d      = OWN0;
          last_grant_d = 1'b0;
        end else if (m1_bus.cyc) begin
          state_d      = OWN1;
          last_grant_d = 1'b1;
        end
      end
      OWN0, OWN1: begin
        if (!own_cyc) begin
          state_d = IDLE;
`ifdef WB_ARB_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_d = DRAIN;
`endif
        end
      end
`ifdef WB_ARB_TIMEOUT_EN
      DRAIN: begin
        if (!own_cyc) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_bus.cyc   = 1'b0;
    out_bus.stb   = 1'b0;
    out_bus.we    = 1'b0;
    out_bus.adr   = 32'h0;
    out_bus.dat_w = 32'h0;
    out_bus.sel   = 4'h0;
    m0_bus.ack    = 1'b0;
    m0_bus.err    = 1'b0;
    m0_bus.dat_r  = 32'h0;
    m1_bus.ack    = 1'b0;
    m1_bus.err    = 1'b0;
    m1_bus.dat_r  = 32'h0;
    grant_out     = {own1, own0};
    if (own_any) begin
      out_bus.cyc   = own_cyc & ~timeout_hit;
      out_bus.stb   = own_stb & ~timeout_hit;
      out_bus.we    = own_we;
      out_bus.adr   = own_adr;
      out_bus.dat_w = own_dat_w;
      out_bus.sel   = own_sel;
    end
    if (own0) begin
      m0_bus.ack   = out_bus.ack & ~timeout_hit;
      m0_bus.err   = out_bus.err | timeout_hit;
      m0_bus.dat_r = out_bus.dat_r;
    end
    if (own1) begin
      m1_bus.ack   = out_bus.ack & ~timeout_hit;
      m1_bus.err   = out_bus.err | timeout_hit;
      m1_bus.dat_r = out_bus.dat_r;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb/tb_wb_arbiter_2m.sv - Directed self-checking bench for wb_arbiter_2m.
module tb_wb_arbiter_2m;
  logic       clk_in = 1'b0;
  logic       reset_in;
  logic [1:0] grant_out;
  int         n_checks = 0;
  int         n_fail = 0;

  wb_bus m0_if ();
  wb_bus m1_if ();
  wb_bus out_if ();

  wb_arbiter_2m #(.TIMEOUT_CYCLES(8)) dut (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .m0_bus    (m0_if),
    .m1_bus    (m1_if),
    .out_bus   (out_if),
    .grant_out (grant_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic idle_all();
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m0_if.we = 1'b0;
    m0_if.adr = 32'h0; m0_if.dat_w = 32'h0; m0_if.sel = 4'h0;
    m1_if.cyc = 1'b0; m1_if.stb = 1'b0; m1_if.we = 1'b0;
    m1_if.adr = 32'h0; m1_if.dat_w = 32'h0; m1_if.sel = 4'h0;
    out_if.ack = 1'b0; out_if.err = 1'b0; out_if.dat_r = 32'h0;
  endtask

  task automatic test_reset();
    idle_all();
    reset_in = 1'b1;
    step();
    step();
    reset_in = 1'b0;
    out_if.ack = 1'b1;
    out_if.dat_r = 32'h12345678;
    #1;
    n_checks++; if (grant_out !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b expected 00", grant_out); end
    n_checks++; if (out_if.cyc !== 1'b0 || out_if.stb !== 1'b0) begin n_fail++; $display("FAIL reset_out_cyc_stb: got %b%b expected 00", out_if.cyc, out_if.stb); end
    n_checks++; if (out_if.adr !== 32'h0 || out_if.sel !== 4'h0) begin n_fail++; $display("FAIL reset_out_adr_sel: got %h/%h expected 0/0", out_if.adr, out_if.sel); end
    n_checks++; if (m0_if.ack !== 1'b0 || m0_if.err !== 1'b0 || m0_if.dat_r !== 32'h0) begin n_fail++; $display("FAIL reset_m0_resp: got %b%b %h expected 00 0", m0_if.ack, m0_if.err, m0_if.dat_r); end
    n_checks++; if (m1_if.ack !== 1'b0 || m1_if.dat_r !== 32'h0) begin n_fail++; $display("FAIL reset_m1_resp: got %b %h expected 0 0", m1_if.ack, m1_if.dat_r); end
    out_if.ack = 1'b0;
    out_if.dat_r = 32'h0;
  endtask

  task automatic test_single_master();
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.we = 1'b0;
    m0_if.adr = 32'h100; m0_if.sel = 4'hF;
    #1;
    n_checks++; if (out_if.cyc !== 1'b0) begin n_fail++; $display("FAIL single_no_early_cyc: got %b expected 0", out_if.cyc); end
    step();
    n_checks++; if (out_if.cyc !== 1'b1 || out_if.adr !== 32'h100) begin n_fail++; $display("FAIL single_cyc_latency: got cyc=%b adr=%h expected 1/100", out_if.cyc, out_if.adr); end
    n_checks++; if (grant_out !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b expected 01", grant_out); end
    step();
    out_if.ack = 1'b1;
    out_if.dat_r = 32'hDEADBEEF;
    #1;
    n_checks++; if (m0_if.ack !== 1'b1 || m0_if.dat_r !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_m0_data: got ack=%b dat=%h expected 1/deadbeef", m0_if.ack, m0_if.dat_r); end
    n_checks++; if (m1_if.ack !== 1'b0 || m1_if.dat_r !== 32'h0) begin n_fail++; $display("FAIL single_m1_quiet: got ack=%b dat=%h expected 0/0", m1_if.ack, m1_if.dat_r); end
    out_if.err = 1'b1;
    #1;
    n_checks++; if (m0_if.err !== 1'b1 || m1_if.err !== 1'b0) begin n_fail++; $display("FAIL single_err_forward: got m0=%b m1=%b expected 1/0", m0_if.err, m1_if.err); end
    step();
    out_if.ack = 1'b0; out_if.err = 1'b0; out_if.dat_r = 32'h0;
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
    step();
    #1;
    n_checks++; if (grant_out !== 2'b00 || out_if.cyc !== 1'b0) begin n_fail++; $display("FAIL single_release: got grant=%b cyc=%b expected 00/0", grant_out, out_if.cyc); end
  endtask

  task automatic test_simultaneous();
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.adr = 32'hA000;
    m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.adr = 32'hB000;
    step();
    out_if.ack = 1'b1;
    #1;
    n_checks++; if (grant_out !== 2'b01 || out_if.adr !== 32'hA000) begin n_fail++; $display("FAIL sim_first_m0: got grant=%b adr=%h expected 01/a000", grant_out, out_if.adr); end
    n_checks++; if (m0_if.ack !== 1'b1 || m1_if.ack !== 1'b0) begin n_fail++; $display("FAIL sim_ack_route: got m0=%b m1=%b expected 1/0", m0_if.ack, m1_if.ack); end
    step();
    out_if.ack = 1'b0;
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
    step();
    #1;
    n_checks++; if (grant_out !== 2'b00 || out_if.cyc !== 1'b0) begin n_fail++; $display("FAIL sim_dead_cycle: got grant=%b cyc=%b expected 00/0", grant_out, out_if.cyc); end
    step();
    #1;
    n_checks++; if (grant_out !== 2'b10 || out_if.adr !== 32'hB000) begin n_fail++; $display("FAIL sim_then_m1: got grant=%b adr=%h expected 10/b000", grant_out, out_if.adr); end
    out_if.ack = 1'b1;
    #1;
    n_checks++; if (m1_if.ack !== 1'b1 || m0_if.ack !== 1'b0) begin n_fail++; $display("FAIL sim_m1_ack: got m1=%b m0=%b expected 1/0", m1_if.ack, m0_if.ack); end
    step();
    out_if.ack = 1'b0;
    m1_if.cyc = 1'b0; m1_if.stb = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_grant [4];
    exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.adr = 32'h10;
    m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.adr = 32'h20;
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      n_checks++; if (grant_out !== exp_grant[i]) begin n_fail++; $display("FAIL rr_grant_%0d: got %b expected %b", i, grant_out, exp_grant[i]); end
      out_if.ack = 1'b1;
      step();
      out_if.ack = 1'b0;
      if (exp_grant[i] == 2'b01) begin m0_if.cyc = 1'b0; m0_if.stb = 1'b0; end
      else begin m1_if.cyc = 1'b0; m1_if.stb = 1'b0; end
      step();
      #1;
      n_checks++; if (grant_out !== 2'b00) begin n_fail++; $display("FAIL rr_gap_%0d: got %b expected 00", i, grant_out); end
      m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
      m1_if.cyc = 1'b1; m1_if.stb = 1'b1;
    end
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
    m1_if.cyc = 1'b0; m1_if.stb = 1'b0;
    step();
  endtask

  task automatic test_burst_hold();
    m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.we = 1'b1;
    m1_if.sel = 4'b0011; m1_if.adr = 32'h3000;
    step();
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.adr = 32'h4000;
    for (int b = 0; b < 3; b++) begin
      m1_if.adr = 32'h3000 + 32'(4 * b);
      m1_if.dat_w = 32'hC0DE0000 + 32'(b);
      out_if.ack = 1'b1;
      #1;
      n_checks++; if (grant_out !== 2'b10 || m0_if.ack !== 1'b0) begin n_fail++; $display("FAIL burst_hold_%0d: got grant=%b m0ack=%b expected 10/0", b, grant_out, m0_if.ack); end
      n_checks++; if (out_if.adr !== 32'h3000 + 32'(4 * b) || out_if.we !== 1'b1 || out_if.sel !== 4'b0011 || out_if.dat_w !== 32'hC0DE0000 + 32'(b)) begin
        n_fail++; $display("FAIL burst_beat_%0d: got adr=%h we=%b sel=%b dat=%h", b, out_if.adr, out_if.we, out_if.sel, out_if.dat_w);
      end
      step();
    end
    out_if.ack = 1'b0;
    m1_if.cyc = 1'b0; m1_if.stb = 1'b0; m1_if.we = 1'b0;
    step();
    #1;
    n_checks++; if (grant_out !== 2'b00) begin n_fail++; $display("FAIL burst_gap: got %b expected 00", grant_out); end
    step();
    #1;
    n_checks++; if (grant_out !== 2'b01 || out_if.adr !== 32'h4000) begin n_fail++; $display("FAIL burst_m0_after: got grant=%b adr=%h expected 01/4000", grant_out, out_if.adr); end
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
    step();
  endtask

  task automatic test_mid_reset();
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.adr = 32'h500;
    step();
    #1;
    n_checks++; if (grant_out !== 2'b01) begin n_fail++; $display("FAIL midrst_owned: got %b expected 01", grant_out); end
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    out_if.ack = 1'b1;
    out_if.dat_r = 32'h55AA55AA;
    #1;
    n_checks++; if (grant_out !== 2'b00 || out_if.cyc !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got grant=%b cyc=%b expected 00/0", grant_out, out_if.cyc); end
    n_checks++; if (m0_if.ack !== 1'b0 || m0_if.dat_r !== 32'h0) begin n_fail++; $display("FAIL midrst_late_ack: got ack=%b dat=%h expected 0/0", m0_if.ack, m0_if.dat_r); end
    out_if.ack = 1'b0;
    out_if.dat_r = 32'h0;
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
    step();
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.adr = 32'h600;
    step();
    m1_if.cyc = 1'b1; m1_if.stb = 1'b1; m1_if.adr = 32'h700;
    for (int k = 1; k <= 7; k++) begin
      #1;
      n_checks++; if (m0_if.err !== 1'b0 || out_if.cyc !== 1'b1) begin n_fail++; $display("FAIL tmo_wait_%0d: got err=%b cyc=%b expected 0/1", k, m0_if.err, out_if.cyc); end
      step();
    end
    #1;
    n_checks++; if (m0_if.err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b expected 1", m0_if.err); end
    n_checks++; if (out_if.cyc !== 1'b0 || out_if.stb !== 1'b0) begin n_fail++; $display("FAIL tmo_cyc_drop: got %b%b expected 00", out_if.cyc, out_if.stb); end
    step();
    out_if.ack = 1'b1;
    #1;
    n_checks++; if (m0_if.err !== 1'b0 || m0_if.ack !== 1'b0 || out_if.cyc !== 1'b0) begin n_fail++; $display("FAIL tmo_drain: got err=%b ack=%b cyc=%b expected 0/0/0", m0_if.err, m0_if.ack, out_if.cyc); end
    out_if.ack = 1'b0;
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0;
    step();
    #1;
    n_checks++; if (grant_out !== 2'b00) begin n_fail++; $display("FAIL tmo_idle: got %b expected 00", grant_out); end
    step();
    #1;
    n_checks++; if (grant_out !== 2'b10 || out_if.adr !== 32'h700) begin n_fail++; $display("FAIL tmo_m1_grant: got grant=%b adr=%h expected 10/700", grant_out, out_if.adr); end
    m1_if.cyc = 1'b0; m1_if.stb = 1'b0;
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_master();
    test_simultaneous();
    test_round_robin();
    test_burst_hold();
    test_mid_reset();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_2m.md
# wb_arbiter_2m

Two-master Wishbone (classic, 32-bit) arbiter sharing one downstream bus between the core's bus master (m0) and a second master (m1, e.g. debug loader or DMA). It sits between the masters' Wishbone ports and the SoC interconnect. It grants the bus per bus cycle (CYC-framed) using round-robin fairness and holds the grant until the owner drops CYC. An optional watchdog aborts cycles the slave never acknowledges.

## Interface
- TIMEOUT_CYCLES, default 255: watchdog limit in clocks, 1..65535. Used only with WB_ARB_TIMEOUT_EN.
- clk_in  input  1  system clock; all logic on rising edge.
- reset_in  input  1  synchronous, active-high reset.
- m0_bus  wb_bus.slave  interface  master 0 (core). Signals: cyc, stb, we, adr[31:0], dat_w[31:0], sel[3:0] in; ack, err, dat_r[31:0] out.
- m1_bus  wb_bus.slave  interface  master 1, same signals as m0_bus.
- out_bus  wb_bus.master  interface  shared downstream bus.
- grant_out  output  2  one-hot current owner, {m1,m0}; 2'b00 when idle.

## Operation
- States: IDLE, OWN0, OWN1, DRAIN (DRAIN exists only with WB_ARB_TIMEOUT_EN).
- IDLE, arbitration:
  - Only m0.cyc set: go to OWN0.
  - Only m1.cyc set: go to OWN1.
  - Both set: grant the master not granted last (register last_grant). Reset value makes m0 win the first tie.
  - last_grant updates on entry to OWNx.
- OWNx:
  - out_bus cyc, stb, we, adr, dat_w, sel are combinationally muxed from master x.
  - Master x sees out_bus ack, err, dat_r directly.
  - On mx.cyc=0, go to IDLE. Ownership persists across multiple stb/ack beats while cyc stays high.
- Non-owner master: ack=0, err=0, dat_r=32'h0. Its request is held pending, not dropped.
- IDLE: out_bus cyc=stb=we=0, adr=dat_w=0, sel=0.
- No reordering and no buffering. Data paths are pure muxes selected by the registered state.

## Timing
- Reset: state=IDLE, last_grant=m1, grant_out=2'b00. All out_bus outputs and all master ack/err/dat_r are 0 from the cycle after the reset edge.
- Reset asserted mid-cycle:
  - Forces IDLE at the next edge and abandons the in-flight transaction.
  - No ack or err is forwarded afterwards.
  - The slave must tolerate CYC dropping.
- Arbitration latency: a request seen in IDLE at edge N drives out_bus.cyc from edge N+1 (one cycle).
- Handoff: owner drops cyc at edge N, giving IDLE at N+1 and the new owner at N+2. There is always exactly one dead cycle between owners.
- ack/err to the owner are zero-latency (combinational) from out_bus.
- An owner holding cyc indefinitely starves the other master. Fairness is only per CYC frame.
- Simultaneous owner-release and other-master request: that is the handoff case above; the pending master wins.

## Configuration
- WB_ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to OWNx and on every out_bus ack or err.
  - It increments each cycle in OWNx while out_bus.stb=1.
  - When the count reaches TIMEOUT_CYCLES without ack/err, in that cycle:
    - the owner receives err=1 for exactly one cycle;
    - out_bus cyc/stb are forced 0;
    - state goes to DRAIN.
  - DRAIN holds out_bus idle, ignores slave ack/err, and returns to IDLE when the owner's cyc=0.
  - The err output is otherwise purely forwarded.
- WB_ARB_TIMEOUT_EN undefined: no counter, no DRAIN state, and TIMEOUT_CYCLES is ignored. A missing ack hangs the bus until reset.

## Test plan
- Single master: m0 reads adr 32'h100, slave acks after 2 cycles with 32'hDEADBEEF. Required:
  - out_bus.cyc rises 1 cycle after m0.cyc;
  - m0 gets dat_r=32'hDEADBEEF with ack;
  - m1 sees ack=0, dat_r=0.
- Simultaneous request from reset: m0 and m1 assert cyc together. Required:
  - m0 granted first (grant_out=01);
  - after m0 drops cyc, one idle cycle, then grant_out=10.
- Round-robin: both masters request continuously, 4-beat-free single cycles each. Required: grants alternate 01,10,01,10, with m1 never waiting more than one m0 frame.
- Burst hold: m1 owns and issues 3 stb/ack beats within one cyc while m0 requests. Required: m0 is not granted until m1.cyc=0; all 3 beats reach out_bus with m1's adr/sel/we.
- Reset mid-transaction: assert reset_in while OWN0 with stb=1. Required: next cycle grant_out=00, out_bus.cyc=0, and a late slave ack is not seen by m0.
- With WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks. Required:
  - m0 gets a single-cycle err on the 8th stb cycle;
  - out_bus.cyc=0 from that cycle;
  - m1's request is granted one cycle after m0 drops cyc.
